// File: rtl/toast_pkg.sv
// toast_pkg: shared opcodes, funct fields, ALU ops, FSM states and decode bundle for the Toast core
package toast_pkg;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;
  typedef enum logic [1:0] {S_IF, S_EX, S_LD, S_HALT} state_e;
  typedef struct packed {
    alu_op_e     alu_op;
    logic        src_a_pc;
    logic        src_b_imm;
    logic        reg_write;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
    logic        illegal;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm;
  } ctrl_t;
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/toast_id_stage.sv
// toast_id_stage: instruction decode, immediate generation and legality check around the register file
module toast_id_stage import toast_pkg::*; (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] instr,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  output ctrl_t       ctrl,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.funct3 = f3;
    ctrl.rd     = instr[11:7];
    case (opc)
      OPC_LUI: begin
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_u;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.src_a_pc  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_u;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl.is_jal    = 1'b1;
        ctrl.imm       = imm_j;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.is_jalr   = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_i;
        ctrl.reg_write = 1'b1;
        ctrl.illegal   = f3 != 3'd0;
      end
      OPC_BRANCH: begin
        ctrl.is_branch = 1'b1;
        ctrl.imm       = imm_b;
        ctrl.illegal   = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        ctrl.is_load   = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_i;
        ctrl.illegal   = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        ctrl.is_store  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_s;
        ctrl.illegal   = f3 > 3'd2;
      end
      OPC_OP_IMM: begin
        ctrl.alu_op    = alu_decode(f3, f3 == F3_SR && f7[5]);
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_i;
        ctrl.reg_write = 1'b1;
        ctrl.illegal   = (f3 == F3_SLL && f7 != F7_BASE) || (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
      end
      OPC_OP: begin
        ctrl.alu_op    = alu_decode(f3, f7[5]);
        ctrl.reg_write = 1'b1;
        ctrl.illegal   = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: ctrl.illegal = f3 == 3'd0;
      default: ctrl.illegal = 1'b1;
    endcase
  end
  toast_regfile regfile_i (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .rs1_addr (instr[19:15]),
    .rs2_addr (instr[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata)
  );
endmodule

// File: rtl/toast_regfile.sv
// toast_regfile: 32x32 register file, two async read ports, one write port; x0 is never written
module toast_regfile (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regfile_data [0:31];
  always_ff @(posedge clk_i) begin
    if (resetn_i) begin
      for (int i = 0; i < 32; i++) regfile_data[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regfile_data[waddr] <= wdata;
    end
  end
  assign rs1_data = regfile_data[rs1_addr];
  assign rs2_data = regfile_data[rs2_addr];
endmodule

// File: rtl/toast_top.sv
// toast_top: multi-cycle RV32I core (IF/EX/LD/HALT) with external synchronous instruction and data memories
module toast_top import toast_pkg::*; (
  input  logic        clk_i,
  input  logic        resetn_i,
  output logic [31:0] IMEM_addr_o,
  input  logic [31:0] IMEM_data_i,
  output logic [31:0] DMEM_addr_o,
  output logic [3:0]  DMEM_wr_byte_en_o,
  output logic [31:0] DMEM_wr_data_o,
  input  logic [31:0] DMEM_rd_data_i,
  output logic        DMEM_rst_o,
  output logic        exception_o
);
  state_e state, state_n;
  logic [31:0] pc, pc_n, rs1, rs2, a, b, alu_res, target, rf_wdata, ld_shift, ld_val;
  logic [4:0] ld_rd, rf_waddr;
  logic [2:0] ld_f3;
  logic [1:0] ld_off;
  logic rf_we, lt, br_cond, taken, mis_ls, trap, mem_go;
  ctrl_t ctrl;
  toast_id_stage id_stage_i (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .instr    (IMEM_data_i),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .ctrl     (ctrl),
    .rs1_data (rs1),
    .rs2_data (rs2)
  );
  assign a = ctrl.src_a_pc ? pc : rs1;
  assign b = ctrl.src_b_imm ? ctrl.imm : rs2;
  always_comb begin
    alu_res = b;
    case (ctrl.alu_op)
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_SLL:  alu_res = a << b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {31'b0, a < b};
      ALU_XOR:  alu_res = a ^ b;
      ALU_SRL:  alu_res = a >> b[4:0];
      ALU_SRA:  alu_res = $signed(a) >>> b[4:0];
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      default:  alu_res = b;
    endcase
  end
  // funct3[2] selects relational compare, [1] unsigned, [0] inverts the result
  assign lt      = ctrl.funct3[1] ? rs1 < rs2 : $signed(rs1) < $signed(rs2);
  assign br_cond = (ctrl.funct3[2] ? lt : rs1 == rs2) ^ ctrl.funct3[0];
  assign taken   = ctrl.is_jal | ctrl.is_jalr | (ctrl.is_branch & br_cond);
  assign target  = ctrl.is_jalr ? {alu_res[31:1], 1'b0} : pc + ctrl.imm;
  assign mis_ls  = ctrl.funct3[1:0] == 2'b01 ? alu_res[0] : ctrl.funct3[1:0] == 2'b10 ? |alu_res[1:0] : 1'b0;
  assign trap    = ctrl.illegal | (taken & |target[1:0]) | ((ctrl.is_load | ctrl.is_store) & mis_ls);
  assign mem_go  = state == S_EX && !trap;
  assign IMEM_addr_o       = pc;
  assign exception_o       = state == S_HALT;
  assign DMEM_rst_o        = !(mem_go && ctrl.is_load);
  assign DMEM_addr_o       = mem_go && (ctrl.is_load || ctrl.is_store) ? alu_res : '0;
  assign DMEM_wr_byte_en_o = !(mem_go && ctrl.is_store) ? 4'h0 : ctrl.funct3[1] ? 4'hF :
                             ctrl.funct3[0] ? (alu_res[1] ? 4'hC : 4'h3) : 4'b0001 << alu_res[1:0];
  assign DMEM_wr_data_o    = !(mem_go && ctrl.is_store) ? '0 : ctrl.funct3[1] ? rs2 :
                             ctrl.funct3[0] ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
  assign ld_shift = DMEM_rd_data_i >> {ld_off, 3'b0};
  assign ld_val   = ld_f3[1] ? DMEM_rd_data_i : ld_f3[0] ?
                    {{16{~ld_f3[2] & ld_shift[15]}}, ld_shift[15:0]} : {{24{~ld_f3[2] & ld_shift[7]}}, ld_shift[7:0]};
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    rf_we    = 1'b0;
    rf_waddr = ctrl.rd;
    rf_wdata = ctrl.is_jal | ctrl.is_jalr ? pc + 32'd4 : alu_res;
    case (state)
      S_IF: state_n = S_EX;
      S_EX: begin
        state_n = trap ? S_HALT : ctrl.is_load ? S_LD : S_IF;
        pc_n    = trap | ctrl.is_load ? pc : taken ? target : pc + 32'd4;
        rf_we   = !trap & ctrl.reg_write;
      end
      S_LD: begin
        state_n  = S_IF;
        pc_n     = pc + 32'd4;
        rf_we    = 1'b1;
        rf_waddr = ld_rd;
        rf_wdata = ld_val;
      end
      S_HALT: ;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (resetn_i) begin
      state  <= S_IF;
      pc     <= '0;
      ld_rd  <= '0;
      ld_f3  <= '0;
      ld_off <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == S_EX) begin
        ld_rd  <= ctrl.rd;
        ld_f3  <= ctrl.funct3;
        ld_off <= alu_res[1:0];
      end
    end
  end
endmodule

// File: tb/tb_toast_top.sv
// tb_toast_top: directed programs with table-driven register/store checks and hand-written trap sequences
module tb_toast_top;
  localparam int OPI = 'h13, OPR = 'h33, LUI = 'h37, LD = 'h03, ST = 'h23, BR = 'h63, JAL = 'h6F, JALR = 'h67;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] imem_addr, imem_q, dmem_addr, dmem_wdata, dmem_q;
  logic [3:0] dmem_be;
  logic dmem_rst, exc;
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:1023];
  int n_cmp = 0, n_bad = 0, pw = 0;
  typedef struct { string name; int r; logic [31:0] exp; } rvec_t;
  typedef struct { string name; logic [3:0] en; logic [31:0] data; logic [31:0] addr; } svec_t;
  typedef struct { logic [3:0] en; logic [31:0] data; logic [31:0] addr; } slog_t;
  rvec_t rt [23];
  svec_t stv [3];
  slog_t slog [$];
  toast_top dut (
    .clk_i             (clk),
    .resetn_i          (rst),
    .IMEM_addr_o       (imem_addr),
    .IMEM_data_i       (imem_q),
    .DMEM_addr_o       (dmem_addr),
    .DMEM_wr_byte_en_o (dmem_be),
    .DMEM_wr_data_o    (dmem_wdata),
    .DMEM_rd_data_i    (dmem_q),
    .DMEM_rst_o        (dmem_rst),
    .exception_o       (exc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    imem_q <= imem[imem_addr[9:2]];
    dmem_q <= dmem_rst ? 32'h0 : dmem[dmem_addr[11:2]];
    for (int n = 0; n < 4; n++)
      if (dmem_be[n]) dmem[dmem_addr[11:2]][8*n +: 8] <= dmem_wdata[8*n +: 8];
  end
  always @(negedge clk) if (|dmem_be) slog.push_back('{dmem_be, dmem_wdata, dmem_addr});
  function automatic logic [31:0] enc_i(int op, int rd, int f3, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int f3, int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int off);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int off);
    return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(int op, int rd, int imm);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask
  task automatic emit(input logic [31:0] w);
    imem[pw] = w;
    pw++;
  endtask
  task automatic new_prog();
    for (int i = 0; i < 256; i++) imem[i] = 32'h00000013;
    pw = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset exc clear", {31'b0, exc}, 32'h0);
    check("reset x1 clear", dut.id_stage_i.regfile_i.regfile_data[1], 32'h0);
    slog.delete();
    rst = 1'b0;
  endtask
  task automatic run_exc(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  function automatic logic [31:0] rf(int r);
    return dut.id_stage_i.regfile_i.regfile_data[r];
  endfunction
  initial begin
    bit ok;
    rt[0]  = '{"alu x1 jal link", 1, 32'h00000044};
    rt[1]  = '{"alu srli x2", 2, 32'h0000000F};
    rt[2]  = '{"alu sra copy x20", 20, 32'hFFFFFFFF};
    rt[3]  = '{"alu sltu x4", 4, 32'h00000001};
    rt[4]  = '{"lui x5", 5, 32'h00002000};
    rt[5]  = '{"addi x6", 6, 32'h00000080};
    rt[6]  = '{"lb x7", 7, 32'hFFFFFF80};
    rt[7]  = '{"lbu x8", 8, 32'h00000080};
    rt[8]  = '{"lw x9", 9, 32'h00002000};
    rt[9]  = '{"beq skip x11", 11, 32'h0};
    rt[10] = '{"beq target x12", 12, 32'h00000002};
    rt[11] = '{"jump skips x13", 13, 32'h0};
    rt[12] = '{"odd base x14", 14, 32'h0000005D};
    rt[13] = '{"jalr link x15", 15, 32'h00000054};
    rt[14] = '{"lh x16", 16, 32'hFFFFFFFF};
    rt[15] = '{"lhu x18", 18, 32'h0000FFFF};
    rt[16] = '{"sub x19", 19, 32'hFFFFFF80};
    rt[17] = '{"slt x21", 21, 32'h00000001};
    rt[18] = '{"bne fallthru x22", 22, 32'h00000005};
    rt[19] = '{"ecall gp", 3, 32'h00000001};
    rt[20] = '{"ecall a7", 17, 32'd93};
    rt[21] = '{"ecall a0", 10, 32'h0};
    rt[22] = '{"x0 zero", 0, 32'h0};
    stv[0] = '{"sb", 4'b0010, 32'h80808080, 32'h00002001};
    stv[1] = '{"sw", 4'b1111, 32'h00002000, 32'h00002000};
    stv[2] = '{"sh", 4'b1100, 32'hFFFFFFFF, 32'h00002002};
    new_prog();
    emit(enc_i(OPI, 1, 0, 0, -1));
    emit(enc_i(OPI, 2, 5, 1, 28));
    emit(enc_r('h20, 2, 1, 5, 3));
    emit(enc_r(0, 1, 0, 3, 4));
    emit(enc_i(OPI, 20, 0, 3, 0));
    emit(enc_u(LUI, 5, 2));
    emit(enc_i(OPI, 6, 0, 0, 'h80));
    emit(enc_s(0, 6, 5, 1));
    emit(enc_i(LD, 7, 0, 5, 1));
    emit(enc_i(LD, 8, 4, 5, 1));
    emit(enc_s(2, 5, 5, 0));
    emit(enc_i(LD, 9, 2, 5, 0));
    emit(enc_b(0, 0, 0, 8));
    emit(enc_i(OPI, 11, 0, 0, 1));
    emit(enc_i(OPI, 12, 0, 0, 2));
    emit(32'h00000013);
    emit(enc_j(1, 12));
    emit(enc_i(OPI, 13, 0, 0, 7));
    emit(enc_i(OPI, 13, 0, 0, 7));
    emit(enc_i(OPI, 14, 0, 0, 'h5D));
    emit(enc_i(JALR, 15, 0, 14, 0));
    emit(enc_i(OPI, 13, 0, 0, 9));
    emit(enc_i(OPI, 13, 0, 0, 9));
    emit(enc_s(1, 20, 5, 2));
    emit(enc_i(LD, 16, 1, 5, 2));
    emit(enc_i(LD, 18, 5, 5, 2));
    emit(enc_r('h20, 6, 0, 0, 19));
    emit(enc_r(0, 0, 19, 2, 21));
    emit(enc_b(1, 0, 0, 8));
    emit(enc_i(OPI, 22, 0, 0, 5));
    emit(enc_i(OPI, 3, 0, 0, 1));
    emit(enc_i(OPI, 17, 0, 0, 93));
    emit(enc_i(OPI, 10, 0, 0, 0));
    emit(32'h00000073);
    repeat (5) @(negedge clk);
    check("rst IMEM_addr", imem_addr, 32'h0);
    check("rst DMEM_addr", dmem_addr, 32'h0);
    check("rst wr_data", dmem_wdata, 32'h0);
    check("rst byte_en", {28'b0, dmem_be}, 32'h0);
    check("rst DMEM_rst", {31'b0, dmem_rst}, 32'h1);
    check("rst exception", {31'b0, exc}, 32'h0);
    slog.delete();
    rst = 1'b0;
    @(negedge clk) check("fetch pc0", imem_addr, 32'h0);
    @(negedge clk) check("fetch pc4", imem_addr, 32'h4);
    repeat (2) @(negedge clk);
    check("fetch pc8 cpi2", imem_addr, 32'h8);
    run_exc(400, ok);
    check("prog1 reaches ecall", {31'b0, ok}, 32'h1);
    foreach (rt[i]) check(rt[i].name, rf(rt[i].r), rt[i].exp);
    check("store count", slog.size(), 32'd3);
    foreach (stv[i]) if (i < slog.size()) begin
      check({stv[i].name, " en"}, {28'b0, slog[i].en}, {28'b0, stv[i].en});
      check({stv[i].name, " data"}, slog[i].data, stv[i].data);
      check({stv[i].name, " addr"}, slog[i].addr, stv[i].addr);
    end
    repeat (4) @(negedge clk);
    check("halt IMEM_addr", imem_addr, 32'h84);
    check("halt exception", {31'b0, exc}, 32'h1);
    check("halt DMEM_rst", {31'b0, dmem_rst}, 32'h1);
    check("halt no stores", slog.size(), 32'd3);
    rst = 1'b1;
    new_prog();
    emit(enc_i(OPI, 1, 0, 0, 5));
    emit(32'hFFFFFFFF);
    emit(enc_i(OPI, 2, 0, 0, 7));
    do_reset();
    run_exc(50, ok);
    check("illegal traps", {31'b0, ok}, 32'h1);
    check("illegal x1 kept", rf(1), 32'h5);
    check("illegal no rd write", rf(31), 32'h0);
    check("illegal stops x2", rf(2), 32'h0);
    check("illegal pc", imem_addr, 32'h4);
    rst = 1'b1;
    new_prog();
    emit(enc_u(LUI, 5, 2));
    emit(enc_i(LD, 6, 2, 5, 2));
    emit(enc_i(OPI, 7, 0, 0, 1));
    do_reset();
    run_exc(50, ok);
    check("mis lw traps", {31'b0, ok}, 32'h1);
    check("mis lw x6", rf(6), 32'h0);
    check("mis lw x7", rf(7), 32'h0);
    check("mis lw pc", imem_addr, 32'h4);
    check("mis lw no enables", slog.size(), 32'd0);
    rst = 1'b1;
    new_prog();
    emit(enc_i(OPI, 1, 0, 0, 5));
    emit(enc_b(0, 0, 0, 2));
    emit(enc_i(OPI, 2, 0, 0, 7));
    do_reset();
    run_exc(50, ok);
    check("mis branch traps", {31'b0, ok}, 32'h1);
    check("mis branch pc", imem_addr, 32'h4);
    check("mis branch x2", rf(2), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
